// File: rtl/data_island_packet_serializer.sv
// HDMI data-island packet serializer: header + four subpackets with BCH parity, one 9-bit word per pixel clock.
// Optional ignored-start detection is built when DATA_ISLAND_SERIALIZER_OVERRUN_EN is defined.
module data_island_packet_serializer (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         start,
  input  logic [23:0]  header,
  input  logic [223:0] sub,
  output logic [8:0]   packet_data,
  output logic         busy,
  output logic         last,
  output logic         overrun
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [4:0]       k_reg, k_next;
  logic             accept;
  logic             send_next;
  logic [31:0]      hframe_reg, hframe_next;
  logic [3:0][63:0] lane_reg, lane_next;
  logic [8:0]       data_reg, data_next;
  logic             busy_reg, last_reg;

  // BCH G(x)=1+x^6+x^7+x^8 over the first nbits of d, LSB first.
  function automatic logic [7:0] bch_ecc(input logic [55:0] d, input int nbits);
    logic [7:0] e;
    logic       fb;
    e = 8'h00;
    for (int i = 0; i < 56; i++) begin
      if (i < nbits) begin
        fb = d[i] ^ e[0];
        e  = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
      end
    end
    return e;
  endfunction

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      SEND: begin
        if (k_reg == 5'd31) begin
          if (start) accept = 1'b1;
          else       state_next = IDLE;
        end else begin
          k_next = k_reg + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      state_next = SEND;
      k_next     = 5'd0;
    end
  end

  assign send_next = (state_next == SEND);

  // Parity is precomputed at latch time so each frame is just data followed by its ECC.
  assign hframe_next = accept ? {bch_ecc({32'd0, header}, 24), header} : hframe_reg;
  assign data_next[0] = send_next & hframe_next[k_next];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [55:0] sub_slice;
      assign sub_slice          = sub[gi*56 +: 56];
      assign lane_next[gi]      = accept ? {bch_ecc(sub_slice, 56), sub_slice} : lane_reg[gi];
      assign data_next[1 + gi]  = send_next & lane_next[gi][{k_next, 1'b0}];
      assign data_next[5 + gi]  = send_next & lane_next[gi][{k_next, 1'b1}];
    end
  endgenerate

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      k_reg      <= 5'd0;
      hframe_reg <= 32'd0;
      lane_reg   <= '0;
      data_reg   <= 9'd0;
      busy_reg   <= 1'b0;
      last_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      hframe_reg <= hframe_next;
      lane_reg   <= lane_next;
      data_reg   <= data_next;
      busy_reg   <= send_next;
      last_reg   <= send_next && (k_next == 5'd31);
    end
  end

  assign packet_data = data_reg;
  assign busy        = busy_reg;
  assign last        = last_reg;

`ifdef DATA_ISLAND_SERIALIZER_OVERRUN_EN
  logic overrun_reg;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) overrun_reg <= 1'b0;
    else          overrun_reg <= overrun_reg | (start && (state_reg == SEND) && (k_reg != 5'd31));
  end

  assign overrun = overrun_reg;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Self-checking bench for data_island_packet_serializer: directed table, hand-written corner sequences, random packets.
module tb_data_island_packet_serializer;

  logic         clk_pixel = 1'b0;
  logic         reset_n;
  logic         start;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [8:0]   packet_data;
  logic         busy;
  logic         last;
  logic         overrun;

  int vectors     = 0;
  int miscompares = 0;
  logic ov_model  = 1'b0;
  logic [8:0] exp_words [32];

  data_island_packet_serializer dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .start       (start),
    .header      (header),
    .sub         (sub),
    .packet_data (packet_data),
    .busy        (busy),
    .last        (last),
    .overrun     (overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [23:0]  hdr;
    logic [223:0] sb;
    logic [7:0]   exp_hecc;
    logic [8:0]   exp_w0;
  } vec_t;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d got=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  // Reference: shift-register division applied to each field as a whole.
  function automatic logic [7:0] ref_bch(input logic [55:0] d, input int nbits);
    logic [7:0] e = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (d[i] != e[0]) e = (e >> 1) ^ 8'h83;
      else              e = e >> 1;
    end
    return e;
  endfunction

  function automatic void build_model(input logic [23:0] hdr, input logic [223:0] sb);
    logic [7:0]  hecc;
    logic [7:0]  secc [4];
    logic [55:0] s [4];
    hecc = ref_bch({32'd0, hdr}, 24);
    for (int n = 0; n < 4; n++) begin
      s[n]    = sb[n*56 +: 56];
      secc[n] = ref_bch(s[n], 56);
    end
    for (int k = 0; k < 32; k++) begin
      exp_words[k][0] = (k < 24) ? hdr[k] : hecc[k-24];
      for (int n = 0; n < 4; n++) begin
        if (k < 28) begin
          exp_words[k][1+n] = s[n][2*k];
          exp_words[k][5+n] = s[n][2*k+1];
        end else begin
          exp_words[k][1+n] = secc[n][2*(k-28)];
          exp_words[k][5+n] = secc[n][2*(k-28)+1];
        end
      end
    end
  endfunction

  function automatic logic [223:0] rand_sub();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge; start is asserted for the following rising edge.
  task automatic run_packet(input logic [23:0] hdr, input logic [223:0] sb, input int inject_k,
                            input int abort_k, input string name,
                            output logic [7:0] got_hecc, output logic [8:0] got_w0);
    build_model(hdr, sb);
    got_hecc = 8'h00;
    got_w0   = 9'h000;
    start  = 1'b1;
    header = hdr;
    sub    = sb;
    @(posedge clk_pixel);
    #1;
    start  = 1'b0;
    header = $urandom;
    sub    = rand_sub();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_pixel);
      start = 1'b0;
      check({name, " data"}, k, 32'(packet_data), 32'(exp_words[k]));
      check({name, " busy"}, k, 32'(busy), 32'd1);
      check({name, " last"}, k, 32'(last), (k == 31) ? 32'd1 : 32'd0);
      check({name, " overrun"}, k, 32'(overrun), 32'(ov_model));
      if (k == 0)  got_w0 = packet_data;
      if (k >= 24) got_hecc[k-24] = packet_data[0];
      if (k == inject_k) begin
        start  = 1'b1;
        header = ~hdr;
        sub    = ~sb;
`ifdef DATA_ISLAND_SERIALIZER_OVERRUN_EN
        ov_model = 1'b1;
`endif
      end
      if (k == abort_k) begin
        reset_n = 1'b0;
        #1;
        check({name, " abort data"}, k, 32'(packet_data), 32'd0);
        check({name, " abort busy"}, k, 32'(busy), 32'd0);
        check({name, " abort last"}, k, 32'(last), 32'd0);
        check({name, " abort overrun"}, k, 32'(overrun), 32'd0);
        ov_model = 1'b0;
        @(negedge clk_pixel);
        reset_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk_pixel);
    start = 1'b0;
    check({name, " idle data"}, 32, 32'(packet_data), 32'd0);
    check({name, " idle busy"}, 32, 32'(busy), 32'd0);
    check({name, " idle last"}, 32, 32'(last), 32'd0);
    check({name, " idle overrun"}, 32, 32'(overrun), 32'(ov_model));
  endtask

  vec_t       table_v [4];
  logic [7:0] hecc_got;
  logic [8:0] w0_got;
  logic       b2b;

  initial begin
    table_v[0] = '{"null",     24'h000000, 224'd0,           8'h00, 9'h000};
    table_v[1] = '{"acr",      24'h000001, 224'd0,           8'h4A, 9'h001};
    table_v[2] = '{"sub0_lsb", 24'h000000, 224'd1,           8'h00, 9'h002};
    table_v[3] = '{"sub3_b1",  24'h000000, 224'd2 << 168,    8'h00, 9'h100};

    reset_n = 1'b0;
    start   = 1'b0;
    header  = 24'd0;
    sub     = 224'd0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset data", 0, 32'(packet_data), 32'd0);
    check("reset busy", 0, 32'(busy), 32'd0);
    check("reset last", 0, 32'(last), 32'd0);
    check("reset overrun", 0, 32'(overrun), 32'd0);
    reset_n = 1'b1;
    expect_idle("post_reset");

    for (int i = 0; i < 4; i++) begin
      run_packet(table_v[i].hdr, table_v[i].sb, -1, -1, table_v[i].name, hecc_got, w0_got);
      check({table_v[i].name, " hecc"}, 24, 32'(hecc_got), 32'(table_v[i].exp_hecc));
      check({table_v[i].name, " word0"}, 0, 32'(w0_got), 32'(table_v[i].exp_w0));
      expect_idle(table_v[i].name);
    end

    // Back-to-back: second start lands on the last cycle of the first packet.
    run_packet(24'h000001, 224'd0, -1, -1, "b2b_a", hecc_got, w0_got);
    check("b2b_a word0", 0, 32'(w0_got), 32'h001);
    run_packet(24'h000000, 224'd0, -1, -1, "b2b_b", hecc_got, w0_got);
    check("b2b_b word0", 0, 32'(w0_got), 32'h000);
    expect_idle("b2b");

    // Ignored start mid-packet.
    run_packet($urandom, rand_sub(), 10, -1, "midstart", hecc_got, w0_got);
    expect_idle("midstart");

    // Reset pulse at k=15, then a fresh complete packet.
    run_packet($urandom, rand_sub(), -1, 15, "abort", hecc_got, w0_got);
    expect_idle("after_abort");
    run_packet($urandom, rand_sub(), -1, -1, "fresh", hecc_got, w0_got);
    expect_idle("fresh");

    for (int i = 0; i < 24; i++) begin
      b2b = $urandom_range(0, 1) == 1;
      run_packet($urandom, rand_sub(), -1, -1, "random", hecc_got, w0_got);
      if (!b2b) expect_idle("random");
    end
    expect_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
